tl45_operand_fetch: RTL
=======================

Name: tl45_operand_fetch

Overview:
Parametrised register-read / operand-fetch stage sitting between decode and execute. It reads the DPRF and owns an internal busy scoreboard with one bit per non-zero register. It selects each operand from the DPRF, one of NFWD forwarding buses or the immediate. When an operand cannot be resolved it raises a RAW/WAW hazard stall and inserts a bubble, instead of passing an unresolved register downstream.

Parameters:
XLEN, 32, data width of registers, immediates and buses
NREGS, 16, architectural registers; r0 reads as DPRF value and is never busy
NFWD, 2, number of operand-forwarding buses; lower index = higher priority
OPW, 5, opcode width
RW, $clog2(NREGS), register-address width (derived)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_pipe_stall  in  1  downstream stall; hold output buffer
i_pipe_flush  in  1  squash output buffer, forwarded upstream
o_pipe_stall  out  1  i_pipe_stall OR hazard (to decode)
o_pipe_flush  out  1  equals i_pipe_flush
i_valid  in  1  decode buffer holds an instruction
i_opcode  in  OPW  opcode
i_ri  in  1  1 = sr2 replaced by immediate
i_wr_dr  in  1  instruction writes i_dr
i_dr, i_sr1, i_sr2  in  RW each  register addresses
i_imm32  in  XLEN  immediate
i_pc  in  XLEN  PC
o_dprf_read_a1, o_dprf_read_a2  out  RW each  DPRF read addresses (= i_sr1, i_sr2)
i_dprf_d1, i_dprf_d2  in  XLEN each  DPRF read data (same cycle)
i_fwd_valid  in  NFWD  bus k carries a result
i_fwd_reg  in  NFWD*RW  bus k destination, slice k
i_fwd_data  in  NFWD*XLEN  bus k data, slice k
i_clr_valid  in  1  writeback/squash completion; clears busy[i_clr_reg]
i_clr_reg  in  RW  register completed
o_busylist  out  NREGS-1  scoreboard, bit r-1 = register r busy
o_valid  out  1  output buffer holds an instruction
o_opcode  out  OPW; o_dr  out  RW; o_wr_dr  out  1
o_sr1_val, o_sr2_val, o_pc  out  XLEN each

Behaviour:
- Reset (async, immediate): all o_* buffer fields = 0, o_valid = 0, scoreboard = 0. o_pipe_stall is combinational and follows its inputs.
- Operand resolution, per operand s. Needed = i_valid and (s = sr1, or s = sr2 with i_ri = 0).
  - ri mode: sr2 value = i_imm32.
  - s == 0 or busy[s] == 0: value = DPRF data.
  - Otherwise the lowest k with i_fwd_valid[k] and i_fwd_reg[k] == s supplies the value.
  - Otherwise unresolved.
- Hazard = i_valid and (any needed operand unresolved, or (i_wr_dr and i_dr != 0 and busy[i_dr])).
- o_pipe_stall = i_pipe_stall | hazard. o_pipe_flush = i_pipe_flush.
- Clock edge, priority order:
  - flush: buffer cleared (o_valid = 0, fields = 0). If the old o_valid and o_wr_dr and o_dr != 0, clear busy[o_dr]. The incoming instruction is not issued.
  - else i_pipe_stall: buffer held, no issue.
  - else hazard or !i_valid: bubble (o_valid = 0, fields = 0).
  - else issue: latch fields and values, o_valid = 1. If i_wr_dr and i_dr != 0, set busy[i_dr].
- Scoreboard update each edge: i_clr_valid clears busy[i_clr_reg], with i_clr_reg == 0 ignored. Same-cycle set and clear of the same register: set wins. Clearing a non-busy bit has no effect. Clear and flush-clear may coincide; both apply.
- Forwarding buses do not modify the scoreboard. Only i_clr_valid retires a busy bit.
- Single-cycle latency: operands sampled in cycle N appear on o_* in cycle N+1.
- Out-of-range register addresses (>= NREGS) are treated as r0.

Test Plan:
- Reset mid-issue: issue ADD r3 then assert i_reset asynchronously → o_valid = 0 and o_busylist = 0 before the next edge.
- Back-to-back RAW with forwarding: issue r1 = …; next instruction reads r1 with fwd bus 1 = (r1, 0xDEADBEEF) → no stall, o_sr1_val = 0xDEADBEEF.
- Priority: both buses carry r2 (bus0 = 0x11, bus1 = 0x22) → o_sr2_val = 0x11.
- Unresolved RAW: r4 busy, no bus match → o_pipe_stall = 1, bubble issued. i_clr_reg = 4 the following cycle with DPRF = 0x5 → issue, o_sr1_val = 0x5.
- Immediate mode: i_ri = 1, i_sr2 = r4 busy, imm = 0x7F → no stall, o_sr2_val = 0x7F.
- Flush and set/clear collision: issue writes r6, then flush → busy[6] = 0. Separately, set r5 and clear r5 in the same cycle → busy[5] = 1.

Source files
------------

// File: rtl/tl45_operand_fetch.sv
// tl45_operand_fetch: register-read / operand-fetch stage between decode and execute.
// Reads the DPRF, resolves each operand from the DPRF, a forwarding bus or the
// immediate, and tracks in-flight destinations in a busy scoreboard. An operand
// that cannot be resolved, or a destination that is still busy, stalls decode and
// sends a bubble downstream.
module tl45_operand_fetch #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 16,
    parameter int unsigned NFWD  = 2,
    parameter int unsigned OPW   = 5,
    parameter int unsigned RW    = $clog2(NREGS)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,

    input  logic                 i_pipe_stall,
    input  logic                 i_pipe_flush,
    output logic                 o_pipe_stall,
    output logic                 o_pipe_flush,

    input  logic                 i_valid,
    input  logic [OPW-1:0]       i_opcode,
    input  logic                 i_ri,
    input  logic                 i_wr_dr,
    input  logic [RW-1:0]        i_dr,
    input  logic [RW-1:0]        i_sr1,
    input  logic [RW-1:0]        i_sr2,
    input  logic [XLEN-1:0]      i_imm32,
    input  logic [XLEN-1:0]      i_pc,

    output logic [RW-1:0]        o_dprf_read_a1,
    output logic [RW-1:0]        o_dprf_read_a2,
    input  logic [XLEN-1:0]      i_dprf_d1,
    input  logic [XLEN-1:0]      i_dprf_d2,

    input  logic [NFWD-1:0]      i_fwd_valid,
    input  logic [NFWD*RW-1:0]   i_fwd_reg,
    input  logic [NFWD*XLEN-1:0] i_fwd_data,

    input  logic                 i_clr_valid,
    input  logic [RW-1:0]        i_clr_reg,
    output logic [NREGS-2:0]     o_busylist,

    output logic                 o_valid,
    output logic [OPW-1:0]       o_opcode,
    output logic [RW-1:0]        o_dr,
    output logic                 o_wr_dr,
    output logic [XLEN-1:0]      o_sr1_val,
    output logic [XLEN-1:0]      o_sr2_val,
    output logic [XLEN-1:0]      o_pc
);

    localparam int unsigned NBUSY = NREGS - 1;

    // Register addresses beyond the architectural file behave as r0.
    function automatic logic [RW-1:0] norm_reg(input logic [RW-1:0] a);
        norm_reg = (32'(a) >= NREGS) ? '0 : a;
    endfunction

    // Busy bit of a register; r0 is never busy.
    function automatic logic busy_of(input logic [NBUSY-1:0] b, input logic [RW-1:0] a);
        busy_of = 1'b0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (a == RW'(r)) busy_of = b[r-1];
        end
    endfunction

    // Lowest-index forwarding bus carrying register a, if any.
    function automatic logic fwd_lookup(
        input  logic [RW-1:0]        a,
        input  logic [NFWD-1:0]      fv,
        input  logic [NFWD*RW-1:0]   fr,
        input  logic [NFWD*XLEN-1:0] fd,
        output logic [XLEN-1:0]      d
    );
        fwd_lookup = 1'b0;
        d          = '0;
        for (int unsigned k = 0; k < NFWD; k++) begin
            if (!fwd_lookup && fv[k] && (norm_reg(fr[k*RW +: RW]) == a)) begin
                fwd_lookup = 1'b1;
                d          = fd[k*XLEN +: XLEN];
            end
        end
    endfunction

    // State
    logic [NBUSY-1:0] busy_q,    busy_d;
    logic             o_valid_q, o_valid_d;
    logic [OPW-1:0]   o_opcode_q, o_opcode_d;
    logic [RW-1:0]    o_dr_q,    o_dr_d;
    logic             o_wr_dr_q, o_wr_dr_d;
    logic [XLEN-1:0]  o_sr1_q,   o_sr1_d;
    logic [XLEN-1:0]  o_sr2_q,   o_sr2_d;
    logic [XLEN-1:0]  o_pc_q,    o_pc_d;

    // Operand resolution signals
    logic [RW-1:0]    sr1_n, sr2_n, dr_n, clr_n;
    logic             sr1_busy, sr2_busy, dr_busy;
    logic             fwd1_hit, fwd2_hit;
    logic [XLEN-1:0]  fwd1_val, fwd2_val;
    logic             ok1, ok2;
    logic [XLEN-1:0]  val1, val2;
    logic             hazard;
    logic             issue;
    logic             flush_clr;

    // Resolve both operands and detect RAW/WAW hazards.
    always_comb begin
        sr1_n    = norm_reg(i_sr1);
        sr2_n    = norm_reg(i_sr2);
        dr_n     = norm_reg(i_dr);
        clr_n    = norm_reg(i_clr_reg);
        sr1_busy = busy_of(busy_q, sr1_n);
        sr2_busy = busy_of(busy_q, sr2_n);
        dr_busy  = busy_of(busy_q, dr_n);
        fwd1_hit = fwd_lookup(sr1_n, i_fwd_valid, i_fwd_reg, i_fwd_data, fwd1_val);
        fwd2_hit = fwd_lookup(sr2_n, i_fwd_valid, i_fwd_reg, i_fwd_data, fwd2_val);

        ok1  = 1'b1;
        val1 = i_dprf_d1;
        if (sr1_busy) begin
            ok1  = fwd1_hit;
            val1 = fwd1_hit ? fwd1_val : i_dprf_d1;
        end

        ok2  = 1'b1;
        val2 = i_dprf_d2;
        if (i_ri) begin
            val2 = i_imm32;
        end else if (sr2_busy) begin
            ok2  = fwd2_hit;
            val2 = fwd2_hit ? fwd2_val : i_dprf_d2;
        end

        hazard = i_valid && (!ok1 || !ok2 || (i_wr_dr && dr_busy));
    end

    // Output buffer next state: flush > downstream stall > bubble > issue.
    always_comb begin
        o_valid_d  = o_valid_q;
        o_opcode_d = o_opcode_q;
        o_dr_d     = o_dr_q;
        o_wr_dr_d  = o_wr_dr_q;
        o_sr1_d    = o_sr1_q;
        o_sr2_d    = o_sr2_q;
        o_pc_d     = o_pc_q;
        issue      = 1'b0;
        flush_clr  = 1'b0;

        if (i_pipe_flush) begin
            flush_clr  = o_valid_q && o_wr_dr_q && (o_dr_q != '0);
            o_valid_d  = 1'b0;
            o_opcode_d = '0;
            o_dr_d     = '0;
            o_wr_dr_d  = 1'b0;
            o_sr1_d    = '0;
            o_sr2_d    = '0;
            o_pc_d     = '0;
        end else if (i_pipe_stall) begin
            issue = 1'b0;
        end else if (hazard || !i_valid) begin
            o_valid_d  = 1'b0;
            o_opcode_d = '0;
            o_dr_d     = '0;
            o_wr_dr_d  = 1'b0;
            o_sr1_d    = '0;
            o_sr2_d    = '0;
            o_pc_d     = '0;
        end else begin
            issue      = 1'b1;
            o_valid_d  = 1'b1;
            o_opcode_d = i_opcode;
            o_dr_d     = dr_n;
            o_wr_dr_d  = i_wr_dr;
            o_sr1_d    = val1;
            o_sr2_d    = val2;
            o_pc_d     = i_pc;
        end
    end

    // Scoreboard next state: clears first, then an issuing write sets (set wins).
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (i_clr_valid && (clr_n == RW'(r))) busy_d[r-1] = 1'b0;
            if (flush_clr && (o_dr_q == RW'(r)))  busy_d[r-1] = 1'b0;
            if (issue && i_wr_dr && (dr_n == RW'(r))) busy_d[r-1] = 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            busy_q     <= '0;
            o_valid_q  <= 1'b0;
            o_opcode_q <= '0;
            o_dr_q     <= '0;
            o_wr_dr_q  <= 1'b0;
            o_sr1_q    <= '0;
            o_sr2_q    <= '0;
            o_pc_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            o_valid_q  <= o_valid_d;
            o_opcode_q <= o_opcode_d;
            o_dr_q     <= o_dr_d;
            o_wr_dr_q  <= o_wr_dr_d;
            o_sr1_q    <= o_sr1_d;
            o_sr2_q    <= o_sr2_d;
            o_pc_q     <= o_pc_d;
        end
    end

    // Upstream handshake is combinational so decode sees the stall this cycle.
    assign o_pipe_stall   = i_pipe_stall | hazard;
    assign o_pipe_flush   = i_pipe_flush;
    assign o_dprf_read_a1 = i_sr1;
    assign o_dprf_read_a2 = i_sr2;

    assign o_busylist = busy_q;
    assign o_valid    = o_valid_q;
    assign o_opcode   = o_opcode_q;
    assign o_dr       = o_dr_q;
    assign o_wr_dr    = o_wr_dr_q;
    assign o_sr1_val  = o_sr1_q;
    assign o_sr2_val  = o_sr2_q;
    assign o_pc       = o_pc_q;

endmodule
